// File: rtl/fmrom_bus_pkg.sv
// Shared constants for the FM BIOS cartridge bus front end: FSM state
// encodings, unlock key addresses and the page-1 window selector.
package fmrom_bus_pkg;

  typedef logic [2:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE      = 3'd0;
  localparam fsm_state_t ST_RD_ADDR   = 3'd1;
  localparam fsm_state_t ST_RD_DATA   = 3'd2;
  localparam fsm_state_t ST_RD_HOLD   = 3'd3;
  localparam fsm_state_t ST_WR_COMMIT = 3'd4;
  localparam fsm_state_t ST_WAIT_REL  = 3'd5;

  localparam logic [15:0] KEY0_ADDR = 16'h7FFE;
  localparam logic [15:0] KEY1_ADDR = 16'h7FFF;

  localparam logic [1:0] WINDOW_HI = 2'b01;

  // True when the upper two address bits select the cartridge window.
  function automatic logic inWindow(input logic [15:0] addr, input logic [1:0] baseHi);
    return (addr[15:14] == baseHi);
  endfunction

endpackage

// File: rtl/fmrom_bus_sync.sv
// Synchronizer for one active-low bus strobe plus detection of its
// assertion edge. The chain holds the active-low level, so resetting it
// to all ones means "strobe inactive".
module bus_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic strobe_n_i,
  output logic active_o,
  output logic rise_o
);

  logic [STAGES-1:0] chain_q;
  logic              prev_q;

  // Shift the raw strobe through the chain and remember the last synced level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chain_q <= '1;
      prev_q  <= 1'b1;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], strobe_n_i};
      prev_q  <= chain_q[STAGES-1];
    end
  end

  assign active_o = ~chain_q[STAGES-1];
  assign rise_o   = prev_q & ~chain_q[STAGES-1];

endmodule

// File: rtl/fmrom_bus_if.sv
// Z80 cartridge-slot front end for the 16 KB FM BIOS memory. Strobes are
// synchronized, accesses in the page-1 window are sequenced against the
// one-clock memory read latency, and writes only reach the memory after
// the two-byte unlock key has been written.
module fmrom_bus_if
  import fmrom_bus_pkg::*;
#(
  parameter logic [1:0] BASE_HI     = WINDOW_HI,
  parameter logic [7:0] KEY0        = 8'h4D,
  parameter logic [7:0] KEY1        = 8'h69,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] bus_addr,
  input  logic [7:0]  bus_din,
  input  logic        bus_sltsl_n,
  input  logic        bus_rd_n,
  input  logic        bus_wr_n,
  output logic [7:0]  bus_dout,
  output logic        bus_doe,
  output logic        bus_wait_n,
  output logic [13:0] rom_address,
  output logic [7:0]  rom_data,
  output logic        rom_wren,
  input  logic [7:0]  rom_q,
  output logic        unlocked
);

  logic rdActive, rdRise, wrActive, wrRise;
  logic addrInWin;

  fsm_state_t  state_q,    state_d;
  logic [13:0] romAddr_q,  romAddr_d;
  logic [7:0]  romData_q,  romData_d;
  logic        wren_q,     wren_d;
  logic [7:0]  dout_q,     dout_d;
  logic        doe_q,      doe_d;
  logic        waitN_q,    waitN_d;
  logic        unlocked_q, unlocked_d;
  logic        keyStage_q, keyStage_d;

  bus_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (
    .clock      (clock),
    .reset_n    (reset_n),
    .strobe_n_i (bus_sltsl_n | bus_rd_n),
    .active_o   (rdActive),
    .rise_o     (rdRise)
  );

  bus_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
    .clock      (clock),
    .reset_n    (reset_n),
    .strobe_n_i (bus_sltsl_n | bus_wr_n),
    .active_o   (wrActive),
    .rise_o     (wrRise)
  );

  assign addrInWin = inWindow(bus_addr, BASE_HI);

  // Next-state logic: accept new accesses only in IDLE, read wins over write.
  always_comb begin
    state_d    = state_q;
    romAddr_d  = romAddr_q;
    romData_d  = romData_q;
    wren_d     = 1'b0;
    dout_d     = dout_q;
    doe_d      = doe_q;
    waitN_d    = waitN_q;
    unlocked_d = unlocked_q;
    keyStage_d = keyStage_q;

    case (state_q)
      ST_IDLE: begin
        if (rdRise && addrInWin) begin
          romAddr_d = bus_addr[13:0];
          waitN_d   = 1'b0;
          state_d   = ST_RD_ADDR;
        end else if (wrRise && addrInWin) begin
          state_d = ST_WAIT_REL;
          if (bus_addr == KEY0_ADDR) begin
            keyStage_d = (bus_din == KEY0);
          end else if (bus_addr == KEY1_ADDR && keyStage_q) begin
            unlocked_d = (bus_din == KEY1) ? ~unlocked_q : 1'b0;
            keyStage_d = 1'b0;
          end else begin
            keyStage_d = 1'b0;
            if (unlocked_q) begin
              romAddr_d = bus_addr[13:0];
              romData_d = bus_din;
              wren_d    = 1'b1;
              state_d   = ST_WR_COMMIT;
            end
          end
        end
      end
      ST_RD_ADDR: begin
        state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        dout_d  = rom_q;
        waitN_d = 1'b1;
        if (rdActive) begin
          doe_d   = 1'b1;
          state_d = ST_RD_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_HOLD: begin
        if (!rdActive) begin
          doe_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_WR_COMMIT: begin
        state_d = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        if (!wrActive) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      romAddr_q  <= '0;
      romData_q  <= '0;
      wren_q     <= 1'b0;
      dout_q     <= '0;
      doe_q      <= 1'b0;
      waitN_q    <= 1'b1;
      unlocked_q <= 1'b0;
      keyStage_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      romAddr_q  <= romAddr_d;
      romData_q  <= romData_d;
      wren_q     <= wren_d;
      dout_q     <= dout_d;
      doe_q      <= doe_d;
      waitN_q    <= waitN_d;
      unlocked_q <= unlocked_d;
      keyStage_q <= keyStage_d;
    end
  end

  assign bus_dout    = dout_q;
  assign bus_doe     = doe_q;
  assign bus_wait_n  = waitN_q;
  assign rom_address = romAddr_q;
  assign rom_data    = romData_q;
  assign rom_wren    = wren_q;
  assign unlocked    = unlocked_q;

endmodule

// File: tb/tb_fmrom_bus_if.sv
// Scoreboard bench for fmrom_bus_if: a behavioural 16 KB memory sits behind
// the DUT, bus tasks push expected read data / memory writes into queues and
// a negedge monitor pops and compares them when the DUT presents them.
module tb_fmrom_bus_if;

  logic        clock;
  logic        reset_n;
  logic [15:0] bus_addr;
  logic [7:0]  bus_din;
  logic        bus_sltsl_n;
  logic        bus_rd_n;
  logic        bus_wr_n;
  logic [7:0]  bus_dout;
  logic        bus_doe;
  logic        bus_wait_n;
  logic [13:0] rom_address;
  logic [7:0]  rom_data;
  logic        rom_wren;
  logic [7:0]  rom_q;
  logic        unlocked;

  logic [7:0]  mem [0:16383];
  logic [7:0]  rdQ [$];
  logic [21:0] wrQ [$];

  int vecs        = 0;
  int miscompares = 0;
  int waitLowCnt  = 0;
  int doeCnt      = 0;
  logic prevDoe   = 1'b0;
  logic prevWren  = 1'b0;

  fmrom_bus_if dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus_addr    (bus_addr),
    .bus_din     (bus_din),
    .bus_sltsl_n (bus_sltsl_n),
    .bus_rd_n    (bus_rd_n),
    .bus_wr_n    (bus_wr_n),
    .bus_dout    (bus_dout),
    .bus_doe     (bus_doe),
    .bus_wait_n  (bus_wait_n),
    .rom_address (rom_address),
    .rom_data    (rom_data),
    .rom_wren    (rom_wren),
    .rom_q       (rom_q),
    .unlocked    (unlocked)
  );

  // 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous memory: write on wren, read data one clock after address
  always @(posedge clock) begin
    if (rom_wren === 1'b1) mem[rom_address] <= rom_data;
    rom_q <= mem[rom_address];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: count strobe-visible cycles and score each read/write the DUT presents
  always @(negedge clock) begin
    logic [7:0]  expRd;
    logic [21:0] expWr;
    if (bus_wait_n === 1'b0) waitLowCnt++;
    if (bus_doe === 1'b1) doeCnt++;
    if (bus_doe === 1'b1 && prevDoe !== 1'b1) begin
      checkOutput("read pending in scoreboard", 32'(rdQ.size() > 0), 32'd1);
      if (rdQ.size() > 0) begin
        expRd = rdQ.pop_front();
        checkOutput("read data", 32'(bus_dout), 32'(expRd));
      end
    end
    if (rom_wren === 1'b1) begin
      checkOutput("wren single cycle", 32'(prevWren), 32'd0);
      checkOutput("write pending in scoreboard", 32'(wrQ.size() > 0), 32'd1);
      if (wrQ.size() > 0) begin
        expWr = wrQ.pop_front();
        checkOutput("write address", 32'(rom_address), 32'(expWr[21:8]));
        checkOutput("write data", 32'(rom_data), 32'(expWr[7:0]));
      end
    end
    prevDoe  = bus_doe;
    prevWren = rom_wren;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
  endtask

  // Bus read: strobe held 'hold' clocks. With two sync stages a held read
  // shows wait_n low for 2 sampled cycles and doe high for hold-2 cycles.
  task automatic busRead(input logic [15:0] addr, input logic sel, input int hold,
                         input logic expData, input logic [7:0] data,
                         input int expWaitLow, input int expDoe, input string tag);
    if (expData) rdQ.push_back(data);
    @(posedge clock); #2;
    waitLowCnt  = 0;
    doeCnt      = 0;
    bus_addr    = addr;
    bus_sltsl_n = ~sel;
    bus_rd_n    = 1'b0;
    repeat (hold) @(posedge clock);
    #2;
    bus_rd_n    = 1'b1;
    bus_sltsl_n = 1'b1;
    idle(6);
    checkOutput({tag, " wait_n low cycles"}, 32'(waitLowCnt), 32'(expWaitLow));
    checkOutput({tag, " doe cycles"}, 32'(doeCnt), 32'(expDoe));
  endtask

  task automatic busWrite(input logic [15:0] addr, input logic [7:0] data, input logic expWrite);
    if (expWrite) wrQ.push_back({addr[13:0], data});
    @(posedge clock); #2;
    bus_addr    = addr;
    bus_din     = data;
    bus_sltsl_n = 1'b0;
    bus_wr_n    = 1'b0;
    idle(6);
    #2;
    bus_wr_n    = 1'b1;
    bus_sltsl_n = 1'b1;
    idle(6);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " bus_dout"}, 32'(bus_dout), 32'h0);
    checkOutput({tag, " bus_doe"}, 32'(bus_doe), 32'h0);
    checkOutput({tag, " bus_wait_n"}, 32'(bus_wait_n), 32'h1);
    checkOutput({tag, " rom_address"}, 32'(rom_address), 32'h0);
    checkOutput({tag, " rom_data"}, 32'(rom_data), 32'h0);
    checkOutput({tag, " rom_wren"}, 32'(rom_wren), 32'h0);
    checkOutput({tag, " unlocked"}, 32'(unlocked), 32'h0);
  endtask

  task automatic unlockKey();
    busWrite(16'h7FFE, 8'h4D, 1'b0);
    busWrite(16'h7FFF, 8'h69, 1'b0);
  endtask

  // Directed stimulus sequence
  initial begin : applyStimulus
    for (int i = 0; i < 16384; i++) mem[i] = 8'(i * 7 + 3);
    mem[14'h0000] = 8'h3C;
    mem[14'h0123] = 8'h77;
    mem[14'h1000] = 8'h81;

    reset_n     = 1'b0;
    bus_addr    = 16'h0000;
    bus_din     = 8'h00;
    bus_sltsl_n = 1'b1;
    bus_rd_n    = 1'b1;
    bus_wr_n    = 1'b1;
    idle(3);
    #1;
    checkResetOutputs("reset");
    @(negedge clock);
    reset_n = 1'b1;
    idle(3);

    // Basic read, data 0x3C
    busRead(16'h4000, 1'b1, 8, 1'b1, 8'h3C, 2, 6, "read 4000");

    // Locked write is dropped, original content reads back
    busWrite(16'h4123, 8'h55, 1'b0);
    busRead(16'h4123, 1'b1, 8, 1'b1, 8'h77, 2, 6, "read 4123 locked");

    // Unlock, write, read back
    unlockKey();
    checkOutput("unlocked after key", 32'(unlocked), 32'h1);
    busWrite(16'h4123, 8'hA5, 1'b1);
    busRead(16'h4123, 1'b1, 8, 1'b1, 8'hA5, 2, 6, "read 4123 unlocked");

    // Same key sequence relocks
    unlockKey();
    checkOutput("relocked by key", 32'(unlocked), 32'h0);

    // Broken key sequence leaves it locked; intervening write dropped
    busWrite(16'h7FFE, 8'h4D, 1'b0);
    busWrite(16'h4000, 8'h00, 1'b0);
    busWrite(16'h7FFF, 8'h69, 1'b0);
    checkOutput("wrong key stays locked", 32'(unlocked), 32'h0);

    // Out-of-window address and deselected slot produce no activity
    busRead(16'h8000, 1'b1, 8, 1'b0, 8'h00, 0, 0, "read 8000");
    busRead(16'h4000, 1'b0, 8, 1'b0, 8'h00, 0, 0, "read no sltsl");

    // Strobe released before data phase: dout loads, doe never asserts
    busRead(16'h5000, 1'b1, 1, 1'b0, 8'h00, 2, 0, "short read 5000");
    checkOutput("short read dout", 32'(bus_dout), 32'h81);

    // Reset during RD_DATA
    @(posedge clock); #2;
    bus_addr    = 16'h4000;
    bus_sltsl_n = 1'b0;
    bus_rd_n    = 1'b0;
    idle(4);
    #2;
    checkOutput("wait_n low before reset", 32'(bus_wait_n), 32'h0);
    reset_n = 1'b0;
    #1;
    checkResetOutputs("reset in RD_DATA");
    bus_rd_n    = 1'b1;
    bus_sltsl_n = 1'b1;
    idle(2);
    #2;
    reset_n = 1'b1;
    idle(4);

    // Reset during WR_COMMIT: pulse cut before the memory samples it
    unlockKey();
    checkOutput("unlocked before abort", 32'(unlocked), 32'h1);
    @(posedge clock); #2;
    bus_addr    = 16'h4200;
    bus_din     = 8'h99;
    bus_sltsl_n = 1'b0;
    bus_wr_n    = 1'b0;
    idle(3);
    #2;
    checkOutput("wren in WR_COMMIT", 32'(rom_wren), 32'h1);
    checkOutput("address in WR_COMMIT", 32'(rom_address), 32'h0200);
    reset_n = 1'b0;
    #1;
    checkResetOutputs("reset in WR_COMMIT");
    bus_wr_n    = 1'b1;
    bus_sltsl_n = 1'b1;
    idle(2);
    #2;
    reset_n = 1'b1;
    idle(4);
    busRead(16'h4200, 1'b1, 8, 1'b1, 8'h03, 2, 6, "read 4200 after abort");

    idle(4);
    checkOutput("read queue drained", 32'(rdQ.size()), 32'd0);
    checkOutput("write queue drained", 32'(wrQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
